// File: rtl/rv32_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero and signed overflow finish right after accept.
module rv32_div #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             signed_op;
  logic [XLEN-1:0]  rs1_mag, rs2_mag;
  logic [XLEN:0]    rem_shift, rem_diff;
  logic             q_bit;
  logic [XLEN-1:0]  rem_next, quo_next;

  // Magnitudes are treated as unsigned, so |INT_MIN| stays 0x80000000.
  always_comb begin
    signed_op = ~op[0];
    rs1_mag   = (signed_op && rs1[XLEN-1]) ? (~rs1 + 1'b1) : rs1;
    rs2_mag   = (signed_op && rs2[XLEN-1]) ? (~rs2 + 1'b1) : rs2;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    rem_shift = {rem_q, dvd_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    q_bit     = ~rem_diff[XLEN];
    rem_next  = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_next  = {quo_q[XLEN-2:0], q_bit};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    res_d     = res_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      S_IDLE: begin
        if (!kill && in_valid) begin
          is_rem_d  = op[1];
          neg_quo_d = signed_op & (rs1[XLEN-1] ^ rs2[XLEN-1]);
          neg_rem_d = signed_op & rs1[XLEN-1];
          dvd_d     = rs1_mag;
          dvs_d     = rs2_mag;
          if (rs2 == '0) begin
            res_d   = op[1] ? rs1 : {XLEN{1'b1}};
            state_d = S_DONE;
          end else if (signed_op && rs1 == INT_MIN && rs2 == {XLEN{1'b1}}) begin
            res_d   = op[1] ? '0 : INT_MIN;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          dvd_d = {dvd_q[XLEN-2:0], 1'b0};
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (is_rem_q) begin
              res_d = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
            end else begin
              res_d = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
            end
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (kill || out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      res_q     <= res_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res       = res_q;

endmodule

// File: tb/tb_rv32_div.sv
// Self-checking bench for rv32_div: directed vector table, hand-written handshake/kill/reset
// sequences, and randomized operations checked against a plain-arithmetic reference model.
module tb_rv32_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  rv32_div #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension division rules expressed with native integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    sa = a;
    sb = b;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one op with out_ready=1; lat counts edges from accept (E0 = 1) to out_valid seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat);
    in_valid  = 1'b1;
    op        = o;
    rs1       = a;
    rs2       = b;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rs1      = $urandom;
    rs2      = $urandom;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    kill      = 1'b0;
    out_ready = 1'b0;
    op        = 2'b00;
    rs1       = '0;
    rs2       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] held;
    int          lat;
    int          seen;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;

    vecs.push_back('{"divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{"remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{"div_m100_7",   2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33});
    vecs.push_back('{"rem_m100_7",   2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33});
    vecs.push_back('{"rem_100_m7",   2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,          33});
    vecs.push_back('{"divu_5_0",     2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{"rem_5_0",      2'b10, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{"div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{"rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back('{"divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
    vecs.push_back('{"div_min_1",    2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  33});
    vecs.push_back('{"div_min_2",    2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  33});
    vecs.push_back('{"remu_max_min", 2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  33});
    vecs.push_back('{"divu_3_5",     2'b01, 32'd3,          32'd5,          32'd0,          33});
    vecs.push_back('{"divu_0_0",     2'b01, 32'd0,          32'd0,          32'hFFFF_FFFF,  1});

    do_reset();
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy",      {31'd0, busy},      32'd0);
    check("reset_res",       res,                32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      $display("vec %-12s op=%0d a=0x%08h b=0x%08h res=0x%08h lat=%0d",
               vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      check({vecs[i].name, "_res"}, r, vecs[i].exp_res);
      check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      check({vecs[i].name, "_idle"}, {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result must hold while out_ready is low, and new requests are refused.
    in_valid = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd9; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    held = res;
    check("bp_res", held, 32'd111);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; op = 2'b01; rs1 = $urandom; rs2 = 32'd3;
      @(posedge clk); #1;
      check("bp_hold_res", res, held);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    $display("seq backpressure res=0x%08h", held);
    run_op(2'b11, 32'd1000, 32'd9, r, lat);
    check("bp_next_res", r, 32'd1);
    check("bp_next_lat", lat, 33);

    // Kill mid-CALC at counter 10 (ten CALC edges after accept).
    in_valid = 1'b1; op = 2'b00; rs1 = 32'd12345; rs2 = 32'd17; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("kill_busy_before", {31'd0, busy}, 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("kill_no_result", seen, 0);
    $display("seq kill_calc stray_valids=%0d", seen);

    // Kill in IDLE beats in_valid.
    in_valid = 1'b1; kill = 1'b1; op = 2'b01; rs1 = 32'd8; rs2 = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("kill_idle_busy", {31'd0, busy}, 32'd0);
    $display("seq kill_idle busy=%0d", busy);

    // Kill in DONE drops the result.
    run_op(2'b01, 32'd7, 32'd0, r, lat);
    in_valid = 1'b1; op = 2'b01; rs1 = 32'd7; rs2 = 32'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("kdone_valid", {31'd0, out_valid}, 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kdone_dropped", {31'd0, out_valid}, 32'd0);
    check("kdone_idle", {31'd0, in_ready}, 32'd1);
    $display("seq kill_done out_valid=%0d", out_valid);

    // Reset mid-CALC.
    in_valid = 1'b1; op = 2'b01; rs1 = 32'd500; rs2 = 32'd3; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_busy",      {31'd0, busy},      32'd0);
    check("rst_mid_res",       res,                32'd0);
    rst_n = 1'b1;
    run_op(2'b01, 32'd9, 32'd3, r, lat);
    check("rst_after_res", r, 32'd3);
    check("rst_after_lat", lat, 33);
    $display("seq reset_mid divu 9/3 res=0x%08h lat=%0d", r, lat);

    // Randomized ops, biased toward the boundary operands.
    for (int t = 0; t < 150; t++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFFF;
        4: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(o, a, b, r, lat);
      $display("rnd %0d op=%0d a=0x%08h b=0x%08h res=0x%08h lat=%0d", t, o, a, b, r, lat);
      check("rnd_res", r, ref_res(o, a, b));
      check("rnd_lat", lat, ref_lat(o, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_div.md
Name: rv32_div

Overview:
- Iterative radix-2 divider implementing RV32M DIV, DIVU, REM and REMU.
- Sequential companion to the single-cycle combinational ALU: the execute stage issues operands over a valid/ready handshake, and receives the result over a second valid/ready handshake several cycles later.
- Produces one quotient bit per clock. RISC-V divide-by-zero and signed-overflow cases finish early.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept a new operation.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1  input  XLEN  dividend (rv32_register_t).
- rs2  input  XLEN  divisor (rv32_register_t).
- kill  input  1  abort the in-flight operation (pipeline flush).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- res  output  XLEN  quotient or remainder (rv32_register_t).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, res=0, busy=0, counter=0.
  - Reset overrides every other input, including mid-operation.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE).
- Accept: in_valid && in_ready at an edge (edge E0).
  - Latch op, rs1 and rs2.
  - Signed ops (DIV, REM): latch |rs1| and |rs2|. Quotient sign = sign1 ^ sign2. Remainder sign = sign1.
- Special cases, IDLE→DONE at E0 with res set:
  - rs2==0: DIV/DIVU res=32'hFFFFFFFF; REM/REMU res=rs1.
  - Signed overflow (rs1==32'h80000000, rs2==32'hFFFFFFFF, op DIV/REM): DIV res=32'h80000000; REM res=0.
  - out_valid is high in the cycle after E0.
- Normal path, IDLE→CALC at E0, counter=0:
  - Each CALC edge runs one restoring step on a 33-bit partial remainder: shift in the next dividend MSB, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - The edge where counter==31 applies sign correction (two's-complement negate where required), selects quotient or remainder into res, and moves to DONE.
  - Fixed latency: out_valid rises after E32, i.e. 33 edges after accept counting E0. It does not depend on the data.
- DONE:
  - out_valid=1; res and out_valid hold stable until out_ready is sampled high.
  - out_valid && out_ready → IDLE, out_valid=0. The next operation can be accepted no earlier than the edge after that.
  - No result is dropped while out_ready stays low.
- kill:
  - In CALC or DONE: → IDLE next edge, out_valid=0, no result delivered.
  - In IDLE: kill has priority over in_valid; nothing is accepted.
- Arithmetic: all magnitudes are unsigned 32-bit. |0x80000000| = 0x80000000 (unsigned), and the result is correct for every non-overflow case.
- Operand inputs are ignored outside the accept edge; changing rs1/rs2 mid-CALC has no effect.
- res keeps its last value in IDLE and in CALC; res is only meaningful while out_valid=1.

Test Plan:
- DIVU rs1=100, rs2=7, out_ready=1 → out_valid exactly 33 edges after accept, res=14; repeat with REMU → res=2.
- DIV rs1=-100 (0xFFFFFF9C), rs2=7 → res=0xFFFFFFF2 (-14); REM → res=0xFFFFFFFE (-2); REM rs1=100, rs2=-7 → res=2.
- Divide by zero: DIVU 5/0 → res=0xFFFFFFFF; REM 5/0 → res=5; both give out_valid the cycle after accept.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → res=0x80000000; REM → 0; both complete early.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → res stable, in_ready=0 throughout; a new in_valid in that window is not accepted. Raise out_ready → IDLE, and the next op is accepted.
- kill at CALC counter=10 → IDLE next edge with no out_valid pulse. Separately, rst_n=0 mid-CALC → all outputs at reset values at the next edge. A new DIVU 9/3 afterward → res=3.
